breath_led_multi: RTL and testbench
===================================

# breath_led_multi

Multi-channel, parametrised breathing-LED driver. One shared timebase produces a PWM frame counter and a triangular brightness ramp. Each channel applies its own mode (off, on, breathe, breathe anti-phase) and drives a registered LED output. It sits directly at the board LED pins and replaces the single-rate, fixed-width breathing block, adding channel count, a selectable polarity, per-channel modes, an enable/freeze control and a half-cycle event pulse.

## Interface
- `CH_NUM`, 4: number of LED channels (≥1).
- `CLK_DIV`, 50: sys_clk cycles per PWM tick (≥1; 50 → 1 µs at 50 MHz).
- `PWM_STEPS`, 1000: ticks per PWM frame, equal to brightness resolution (≥2).
- `STEP_FRAMES`, 1: PWM frames per brightness step (≥1).
- `LED_ACTIVE_LOW`, 1: 1 → lit = 0, dark = 1; 0 → lit = 1, dark = 0.
- `sys_clk` input, 1: system clock. One clock.
- `sys_rst_n` input, 1: asynchronous, active-low reset.
- `en` input, 1: 1 = run; 0 = freeze all counters and force every output dark.
- `mode_in` input, 2*CH_NUM: channel i mode at [2i+1:2i]. 00 off, 01 on, 10 breathe, 11 breathe anti-phase.
- `led_out` output, CH_NUM: registered LED drive, polarity per LED_ACTIVE_LOW.
- `half_done` output, 1: one-cycle pulse when the ramp direction toggles.

## Operation
- Widths: each counter is $clog2(max+1) bits, with a minimum of 1. All comparisons are unsigned. No counter ever exceeds its max; each wraps to 0.
- Shared counters advance only while `en`=1:
  - `div_cnt` runs 0..CLK_DIV-1. `tick` = (div_cnt==CLK_DIV-1). When CLK_DIV=1, tick is constant 1.
  - `pwm_cnt` runs 0..PWM_STEPS-1 and advances on tick. `frame_end` = tick && pwm_cnt==PWM_STEPS-1.
  - `frm_cnt` runs 0..STEP_FRAMES-1 and advances on frame_end. `step` = frame_end && frm_cnt==STEP_FRAMES-1.
  - `duty` runs 0..PWM_STEPS-1 and advances on step.
  - `dir` toggles on step && duty==PWM_STEPS-1. The same condition registers `half_done`=1 for exactly one cycle.
- Brightness: bright = dir ? (PWM_STEPS-1-duty) : duty. The anti-phase value is bright_n = PWM_STEPS-1-bright.
- Channel lit conditions (next value of the registered output):
  - Mode 00: never lit.
  - Mode 01: always lit.
  - Mode 10: lit when pwm_cnt < bright.
  - Mode 11: lit when pwm_cnt < bright_n.
  - `en`=0 overrides every mode to dark.
- Brightness range: bright=0 is fully dark. bright=PWM_STEPS-1 gives PWM_STEPS-1 lit ticks out of PWM_STEPS.
- Full breath period = 2·PWM_STEPS·STEP_FRAMES·PWM_STEPS·CLK_DIV cycles.
- Freeze: when `en` goes 0, every counter holds its value. When `en` returns to 1, counting resumes from the held values. Nothing is cleared.
- Mode change: takes effect on the output the next cycle. Mode does not affect the shared counters.
- Reset is asynchronous and may occur mid-frame. It returns all state to reset values immediately. The first count happens on the first clock edge after deassertion with `en`=1.

## Timing
- Reset values:
  - div_cnt, pwm_cnt, frm_cnt, duty, dir all 0.
  - half_done = 0.
  - led_out = {CH_NUM{LED_ACTIVE_LOW}}, i.e. all dark.
- Latency is 1 cycle from counter state and inputs to led_out / half_done. Output is registered. No combinational path from input to output.
- Simultaneous events:
  - At the final step of a half cycle, duty wraps to 0 and dir toggles on the same edge.
  - half_done asserts on the following cycle.
  - No brightness glitch: bright passes from PWM_STEPS-1 to PWM_STEPS-1 in rising→falling order, and from 0 to 0 in falling→rising order.
- `en` deasserted in the same cycle as a terminal count: that count does not occur. half_done stays 0.

## Structure
- Package `breath_pkg` holds:
  - Mode encoding constants MODE_OFF=2'b00, MODE_ON=2'b01, MODE_BREATH=2'b10, MODE_ANTI=2'b11.
  - A function for counter width, max($clog2(n+1),1).
- Sub-module `breath_timebase`: div/pwm/frm/duty/dir counters plus half_done. Outputs pwm_cnt, bright, bright_n and half_done.
- The top instantiates `breath_timebase` once and uses a generate loop of CH_NUM per-channel compare/mode/polarity registers.

## Test plan
Unless stated otherwise, the parameters are CH_NUM=4, CLK_DIV=2, PWM_STEPS=4, STEP_FRAMES=1, LED_ACTIVE_LOW=1.
- Reset: hold reset and release with `en`=1. led_out=4'b1111 during reset and on the first edge after release. half_done=0.
- Period: all channels in mode 10. half_done pulses at cycles 32, 64, 96… after release. During the first half, the lit (0) tick count per 8-cycle frame runs 0,1,2,3. During the second half it runs 3,2,1,0.
- Modes: mode_in=8'b11_10_01_00. ch0 stays 1 and ch1 stays 0 throughout. In every frame, the lit ticks of ch2 plus ch3 sum to 3.
- Freeze: drop `en` at cycle 13 for 20 cycles. led_out=4'b1111 throughout the freeze. After resume, the first half_done arrives 20 cycles later than without the freeze (cycle 52).
- Polarity and scaling: LED_ACTIVE_LOW=0, STEP_FRAMES=3, CLK_DIV=1. Reset value is 4'b0000. half_done occurs every 48 cycles.
- Async reset mid-ramp: assert sys_rst_n=0 at cycle 41, off a clock edge. led_out becomes 4'b1111 without waiting for a clock edge. After release, behaviour matches the period test from time zero.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-LED driver: channel mode encodings
// and the counter width helper used to size every counter.
package breath_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_ON     = 2'b01;
  localparam logic [1:0] MODE_BREATH = 2'b10;
  localparam logic [1:0] MODE_ANTI   = 2'b11;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/breath_timebase.sv
// Shared timebase: clock divider, PWM frame counter, frame prescaler and the
// triangular brightness ramp, plus the half-cycle event pulse.
module breath_timebase
  import breath_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int PWM_STEPS   = 1000,
  parameter int STEP_FRAMES = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  output logic [cnt_width(PWM_STEPS-1)-1:0]    pwm_cnt,
  output logic [cnt_width(PWM_STEPS-1)-1:0]    bright,
  output logic [cnt_width(PWM_STEPS-1)-1:0]    bright_n,
  output logic                                 half_done
);

  localparam int DIV_W = cnt_width(CLK_DIV - 1);
  localparam int PWM_W = cnt_width(PWM_STEPS - 1);
  localparam int FRM_W = cnt_width(STEP_FRAMES - 1);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [PWM_W-1:0] PWM_MAX = PWM_W'(PWM_STEPS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(STEP_FRAMES - 1);

  logic [DIV_W-1:0] div_d, div_q;
  logic [PWM_W-1:0] pwm_d, pwm_q;
  logic [FRM_W-1:0] frm_d, frm_q;
  logic [PWM_W-1:0] duty_d, duty_q;
  logic             dir_d, dir_q;
  logic             half_done_d, half_done_q;
  logic             tick, frame_end, step, half_flip;

  // Each counter only moves when every faster counter below it wraps; en=0 freezes all.
  always_comb begin
    tick        = (div_q == DIV_MAX);
    frame_end   = tick && (pwm_q == PWM_MAX);
    step        = frame_end && (frm_q == FRM_MAX);
    half_flip   = step && (duty_q == PWM_MAX);
    div_d       = div_q;
    pwm_d       = pwm_q;
    frm_d       = frm_q;
    duty_d      = duty_q;
    dir_d       = dir_q;
    half_done_d = 1'b0;
    if (en) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick)      pwm_d  = (pwm_q == PWM_MAX)  ? '0 : pwm_q + PWM_W'(1);
      if (frame_end) frm_d  = (frm_q == FRM_MAX)  ? '0 : frm_q + FRM_W'(1);
      if (step)      duty_d = (duty_q == PWM_MAX) ? '0 : duty_q + PWM_W'(1);
      if (half_flip) dir_d  = ~dir_q;
      half_done_d = half_flip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      pwm_q       <= '0;
      frm_q       <= '0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      half_done_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      pwm_q       <= pwm_d;
      frm_q       <= frm_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      half_done_q <= half_done_d;
    end
  end

  // Falling half mirrors duty so the ramp turns around without a glitch.
  always_comb begin
    bright   = dir_q ? (PWM_MAX - duty_q) : duty_q;
    bright_n = PWM_MAX - bright;
  end

  assign pwm_cnt   = pwm_q;
  assign half_done = half_done_q;

endmodule

// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED driver: one shared timebase feeding per-channel
// mode selection, PWM compare and polarity-correct registered LED outputs.
module breath_led_multi
  import breath_pkg::*;
#(
  parameter int CH_NUM         = 4,
  parameter int CLK_DIV        = 50,
  parameter int PWM_STEPS      = 1000,
  parameter int STEP_FRAMES    = 1,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  en,
  input  logic [2*CH_NUM-1:0]   mode_in,
  output logic [CH_NUM-1:0]     led_out,
  output logic                  half_done
);

  localparam int   PWM_W = cnt_width(PWM_STEPS - 1);
  localparam logic DARK  = (LED_ACTIVE_LOW != 0);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] bright;
  logic [PWM_W-1:0] bright_n;

  breath_timebase #(
    .CLK_DIV     (CLK_DIV),
    .PWM_STEPS   (PWM_STEPS),
    .STEP_FRAMES (STEP_FRAMES)
  ) u_timebase (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .en        (en),
    .pwm_cnt   (pwm_cnt),
    .bright    (bright),
    .bright_n  (bright_n),
    .half_done (half_done)
  );

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic lit;
    logic led_d, led_q;

    always_comb begin
      lit = 1'b0;
      case (mode_in[2*i +: 2])
        MODE_OFF:    lit = 1'b0;
        MODE_ON:     lit = 1'b1;
        MODE_BREATH: lit = (pwm_cnt < bright);
        MODE_ANTI:   lit = (pwm_cnt < bright_n);
        default:     lit = 1'b0;
      endcase
      led_d = (en && lit) ? ~DARK : DARK;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) led_q <= DARK;
      else            led_q <= led_d;
    end

    assign led_out[i] = led_q;
  end

endmodule

// File: tb/tb_breath_led_multi.sv
// Bench for breath_led_multi: two configurations driven in lockstep and
// compared each cycle against an arithmetic model of the breathing ramp.
module tb_breath_led_multi;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       en;
  logic [7:0] mode_in;
  logic [3:0] led_a, led_b;
  logic       half_a, half_b;

  int checks = 0;
  int errors = 0;
  int n_en;
  int cyc;
  int first_half_a;
  int first_half_b;

  always #5 sys_clk = ~sys_clk;

  breath_led_multi #(
    .CH_NUM(4), .CLK_DIV(2), .PWM_STEPS(4), .STEP_FRAMES(1), .LED_ACTIVE_LOW(1)
  ) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode_in(mode_in),
    .led_out(led_a), .half_done(half_a)
  );

  breath_led_multi #(
    .CH_NUM(4), .CLK_DIV(1), .PWM_STEPS(4), .STEP_FRAMES(3), .LED_ACTIVE_LOW(0)
  ) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode_in(mode_in),
    .led_out(led_b), .half_done(half_b)
  );

  // n = enabled clock edges since reset; everything follows from it arithmetically.
  function automatic bit model_lit(input int n, input int cdiv, input int p,
                                   input int sf, input logic [1:0] mode);
    int pwm, steps, duty, bright;
    pwm    = (n / cdiv) % p;
    steps  = n / (cdiv * p * sf);
    duty   = steps % p;
    bright = (((steps / p) % 2) == 1) ? (p - 1 - duty) : duty;
    case (mode)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return pwm < bright;
      default: return pwm < (p - 1 - bright);
    endcase
  endfunction

  function automatic logic [3:0] model_led(input int n, input int cdiv, input int p,
                                           input int sf, input bit active_low,
                                           input bit en_v, input logic [7:0] modes);
    logic [3:0] led;
    for (int ch = 0; ch < 4; ch++) begin
      led[ch] = (en_v && model_lit(n, cdiv, p, sf, modes[2*ch +: 2])) ^ active_low;
    end
    return led;
  endfunction

  function automatic bit model_half(input int n, input int cdiv, input int p,
                                    input int sf, input bit en_v);
    int s0, s1;
    if (!en_v) return 1'b0;
    s0 = n / (cdiv * p * sf);
    s1 = (n + 1) / (cdiv * p * sf);
    return (s1 != s0) && ((s1 % p) == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit en_v, input logic [7:0] modes);
    en      = en_v;
    mode_in = modes;
  endtask

  task automatic clockCycle();
    logic [3:0] exp_a, exp_b;
    bit         exp_ha, exp_hb, en_s;
    logic [7:0] m_s;
    @(posedge sys_clk);
    en_s   = en;
    m_s    = mode_in;
    exp_a  = model_led(n_en, 2, 4, 1, 1'b1, en_s, m_s);
    exp_b  = model_led(n_en, 1, 4, 3, 1'b0, en_s, m_s);
    exp_ha = model_half(n_en, 2, 4, 1, en_s);
    exp_hb = model_half(n_en, 1, 4, 3, en_s);
    if (en_s) n_en++;
    cyc++;
    #1;
    checkOutput("led_a", 32'(led_a), 32'(exp_a));
    checkOutput("led_b", 32'(led_b), 32'(exp_b));
    checkOutput("half_a", 32'(half_a), 32'(exp_ha));
    checkOutput("half_b", 32'(half_b), 32'(exp_hb));
    if (half_a && first_half_a < 0) first_half_a = cyc;
    if (half_b && first_half_b < 0) first_half_b = cyc;
  endtask

  task automatic clearModel();
    n_en         = 0;
    cyc          = 0;
    first_half_a = -1;
    first_half_b = -1;
  endtask

  task automatic doReset(input logic [7:0] modes);
    applyStimulus(1'b1, modes);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      checkOutput("rst_led_a", 32'(led_a), 32'h0000_000f);
      checkOutput("rst_led_b", 32'(led_b), 32'h0000_0000);
      checkOutput("rst_half_a", 32'(half_a), 32'h0);
      checkOutput("rst_half_b", 32'(half_b), 32'h0);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clearModel();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    en        = 1'b1;
    mode_in   = 8'h00;
    clearModel();

    // Reset release and breathing period on both configurations
    doReset(8'b10_10_10_10);
    repeat (100) clockCycle();
    checkOutput("period_half_a", 32'(first_half_a), 32'd32);
    checkOutput("period_half_b", 32'(first_half_b), 32'd48);

    // Mixed modes: off, on, breathe, anti-phase
    doReset(8'b11_10_01_00);
    repeat (64) clockCycle();

    // Freeze for 20 cycles starting at cycle 13
    doReset(8'b10_10_10_10);
    for (int c = 1; c <= 80; c++) begin
      applyStimulus(!(c >= 13 && c < 33), 8'b10_10_10_10);
      clockCycle();
    end
    checkOutput("freeze_half_a", 32'(first_half_a), 32'd52);
    checkOutput("freeze_half_b", 32'(first_half_b), 32'd68);

    // Randomised modes and enable
    doReset(8'($urandom));
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(9) != 0, 8'($urandom));
      clockCycle();
    end

    // Asynchronous reset mid-ramp, asserted away from a clock edge
    doReset(8'b10_10_10_10);
    repeat (41) clockCycle();
    #3;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_led_a", 32'(led_a), 32'h0000_000f);
    checkOutput("async_led_b", 32'(led_b), 32'h0000_0000);
    checkOutput("async_half_a", 32'(half_a), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clearModel();
    repeat (100) clockCycle();
    checkOutput("async_period_a", 32'(first_half_a), 32'd32);
    checkOutput("async_period_b", 32'(first_half_b), 32'd48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
